// File: rtl/tod_slot_timer.sv
// tod_slot_timer: slot/tick time-of-day counter aligned to frame sync, with lock tracking and RAM0 read window.
// Define TOD_INTERNAL_SYNC_EN to replace sync_in with an internal once-per-frame pulse generator.
module tod_slot_timer #(
    parameter int TICKS_PER_SLOT = 2000,
    parameter int SLOT_MAX       = 976,
    parameter int SYNC_LAT       = 3,
    parameter int TOL            = 8,
    parameter int MISS_FRAMES    = 3,
    parameter int RD_SLOT        = 974,
    parameter int RD_LEN         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sync_in,
    output logic [20:0] tod_h,
    output logic [10:0] tod_l,
    output logic        slot_start,
    output logic        frame_start,
    output logic        ram0_rd_en,
    output logic [1:0]  lock_state,
    output logic [15:0] slip_cnt
);
    localparam logic [10:0] L_MAX = 11'(TICKS_PER_SLOT - 1);
    localparam logic [10:0] L_LAT = 11'(SYNC_LAT);
    localparam logic [10:0] L_RD  = 11'(RD_LEN);
    localparam logic [20:0] H_MAX = 21'(SLOT_MAX);
    localparam logic [20:0] H_RD  = 21'(RD_SLOT);
    localparam logic signed [12:0] E_LAT  = 13'(SYNC_LAT);
    localparam logic signed [12:0] E_WRAP = 13'(TICKS_PER_SLOT + SYNC_LAT);
    localparam logic signed [12:0] E_TOL  = 13'(TOL);
    localparam logic [7:0] M_MAX = 8'(MISS_FRAMES);
    localparam logic [7:0] M_HIT = 8'(MISS_FRAMES - 1);

    typedef enum logic [1:0] {UNLOCKED = 2'b00, ACQUIRE = 2'b01, LOCKED = 2'b10, HOLDOVER = 2'b11} state_t;
    state_t state, state_nxt;

    logic s1, s2, s3, det_in, sync_rise;
    logic [7:0] miss;
    logic l_wrap, f_wrap, wrap, miss_hit, in_tol, slip_inc;
    logic [10:0] nat_l, nxt_l;
    logic [20:0] nat_h, nxt_h;
    logic signed [12:0] err;

`ifdef TOD_INTERNAL_SYNC_EN
    localparam logic [31:0] GEN_PERIOD = 32'((SLOT_MAX + 1) * TICKS_PER_SLOT - 1);
    logic [31:0] gen_cnt;
    logic gen_pulse;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_cnt   <= 32'd99;
            gen_pulse <= 1'b0;
        end else begin
            gen_pulse <= gen_cnt == 32'd0;
            gen_cnt   <= gen_cnt == 32'd0 ? GEN_PERIOD : gen_cnt - 32'd1;
        end
    end
    assign det_in = gen_pulse;
`else
    assign det_in = s2;
`endif

    assign sync_rise = det_in & ~s3;
    assign l_wrap    = tod_l == L_MAX;
    assign f_wrap    = l_wrap && tod_h == H_MAX;
    assign nat_l     = l_wrap ? 11'd0 : tod_l + 11'd1;
    assign nat_h     = l_wrap ? (tod_h == H_MAX ? 21'd0 : tod_h + 21'd1) : tod_h;
    // Positions in the last slot sit just before the target, so their error is negative.
    assign err       = nat_h == 21'd0 ? $signed({2'b00, nat_l}) - E_LAT : $signed({2'b00, nat_l}) - E_WRAP;
    assign in_tol    = (nat_h == 21'd0 || nat_h == H_MAX) && err >= -E_TOL && err <= E_TOL;
    // Every sync edge lands on the target; an in-tolerance edge with zero error is the natural count anyway.
    assign nxt_l     = sync_rise ? L_LAT : nat_l;
    assign nxt_h     = sync_rise ? 21'd0 : nat_h;
    assign wrap      = f_wrap && !sync_rise;
    assign miss_hit  = wrap && miss == M_HIT;
    assign slip_inc  = sync_rise && state == LOCKED && in_tol && err != 13'sd0;
    assign lock_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= UNLOCKED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: state_nxt = sync_rise ? ACQUIRE : UNLOCKED;
            ACQUIRE:  state_nxt = sync_rise ? (in_tol ? LOCKED : ACQUIRE) : (miss_hit ? UNLOCKED : ACQUIRE);
            LOCKED:   state_nxt = sync_rise ? (in_tol ? LOCKED : ACQUIRE) : (miss_hit ? HOLDOVER : LOCKED);
            HOLDOVER: state_nxt = sync_rise ? (in_tol ? LOCKED : ACQUIRE) : HOLDOVER;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            tod_h       <= 21'd0;
            tod_l       <= 11'd0;
            slot_start  <= 1'b0;
            frame_start <= 1'b0;
            ram0_rd_en  <= 1'b0;
            miss        <= 8'd0;
            slip_cnt    <= 16'd0;
        end else begin
            s1          <= sync_in;
            s2          <= s1;
            s3          <= det_in;
            tod_h       <= nxt_h;
            tod_l       <= nxt_l;
            slot_start  <= nxt_l == 11'd0;
            frame_start <= nxt_l == 11'd0 && nxt_h == 21'd0;
            ram0_rd_en  <= nxt_h == H_RD && nxt_l < L_RD;
            miss        <= sync_rise ? 8'd0 : (wrap && miss != M_MAX ? miss + 8'd1 : miss);
            slip_cnt    <= slip_inc && slip_cnt != 16'hFFFF ? slip_cnt + 16'd1 : slip_cnt;
        end
    end
endmodule

// File: tb/tb_tod_slot_timer.sv
// tb_tod_slot_timer: directed bench for tod_slot_timer on a shortened frame (10 slots x 20 ticks).
module tb_tod_slot_timer;
    localparam int T   = 20;
    localparam int SM  = 9;
    localparam int LAT = 3;
    localparam int RDS = 7;
    localparam int RDL = 16;
    localparam int FR  = (SM + 1) * T;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_in = 1'b0;
    logic [20:0] tod_h;
    logic [10:0] tod_l;
    logic        slot_start, frame_start, ram0_rd_en;
    logic [1:0]  lock_state;
    logic [15:0] slip_cnt;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int nfs = 0;
    int nrd = 0;

    always #5 clk = ~clk;

    tod_slot_timer #(
        .TICKS_PER_SLOT(T), .SLOT_MAX(SM), .SYNC_LAT(LAT), .TOL(8),
        .MISS_FRAMES(3), .RD_SLOT(RDS), .RD_LEN(RDL)
    ) dut (
        .clk(clk), .rst(rst), .sync_in(sync_in),
        .tod_h(tod_h), .tod_l(tod_l),
        .slot_start(slot_start), .frame_start(frame_start), .ram0_rd_en(ram0_rd_en),
        .lock_state(lock_state), .slip_cnt(slip_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic zero(input string tag);
        chk({tag, "_tod"}, {tod_h, tod_l}, 0);
        chk({tag, "_strobes"}, {slot_start, frame_start, ram0_rd_en}, 0);
        chk({tag, "_lock"}, lock_state, 0);
        chk({tag, "_slip"}, slip_cnt, 0);
    endtask

    // One clock; pos is the bench's expected frame position (slot*T + tick).
    task automatic clk1(input bit ld);
        logic [31:0] e;
        @(posedge clk);
        #1;
        pos = ld ? LAT : (pos + 1) % FR;
        e = {21'(pos / T), 11'(pos % T)};
        chk("tod", {tod_h, tod_l}, e);
        chk("slot_start", slot_start, 32'(pos % T == 0));
        chk("frame_start", frame_start, 32'(pos == 0));
        chk("ram0_rd_en", ram0_rd_en, 32'(pos / T == RDS && pos % T < RDL));
        nfs += int'(frame_start);
        nrd += int'(ram0_rd_en);
    endtask

    task automatic run(input int n);
        repeat (n) clk1(1'b0);
    endtask

    // Two synchroniser clocks, then the edge-detected pulse loads the target on the third.
    task automatic pulse();
        sync_in = 1'b1;
        clk1(1'b0);
        clk1(1'b0);
        clk1(1'b1);
        sync_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        zero("reset");
        rst = 1'b0;
        pos = 0;
        run(2 * FR);
        chk("frames_seen", nfs, 2);
        chk("window_clocks", nrd, 2 * RDL);
        chk("free_lock", lock_state, 0);
        run(60);
        pulse();
        chk("acq_lock", lock_state, 1);
        run(197);
        pulse();
        chk("locked", lock_state, 2);
        chk("locked_slip", slip_cnt, 0);
        run(192);
        pulse();
        chk("early_lock", lock_state, 2);
        chk("early_slip", slip_cnt, 1);
        run(17);
        pulse();
        chk("late_lock", lock_state, 1);
        run(197);
        pulse();
        chk("relock", lock_state, 2);
        chk("relock_slip", slip_cnt, 1);
        run(596);
        chk("two_miss_lock", lock_state, 2);
        run(1);
        chk("holdover", lock_state, 3);
        pulse();
        chk("hold_relock", lock_state, 2);
        chk("hold_slip", slip_cnt, 1);
        run(194);
        pulse();
        chk("wrap_edge_lock", lock_state, 2);
        chk("wrap_edge_slip", slip_cnt, 2);
        run(397);
        chk("wrap_edge_miss_clr", lock_state, 2);
        run(20);
        pulse();
        chk("late2_lock", lock_state, 1);
        run(596);
        chk("acq_two_miss", lock_state, 1);
        run(1);
        chk("acq_unlock", lock_state, 0);
        run(RDS * T + 8);
        chk("win_open", ram0_rd_en, 1);
        rst = 1'b1;
        #1;
        zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        zero("rst_hold");
        rst = 1'b0;
        pos = 0;
        run(10);
        chk("post_rst_lock", lock_state, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tod_slot_timer.md
Name: tod_slot_timer

Overview:
- Generates the timeslot time-of-day count (tod_h slot index, tod_l tick within slot) at 80 MHz, consumed by the Tx/Rx switching controller.
- Aligns the count to an external frame sync pulse and tracks lock state.
- Generates the per-frame RAM0 read window (ram0_rd_en) that lets the controller fetch the Tx/Tl words before the slot-975 load point.

Parameters:
- TICKS_PER_SLOT, 2000: tod_l wraps at TICKS_PER_SLOT-1. Maximum 2048.
- SLOT_MAX, 976: tod_h wraps after SLOT_MAX. Frame length is (SLOT_MAX+1) slots.
- SYNC_LAT, 3: synchroniser plus edge-detect latency that is compensated on load.
- TOL, 8: phase error in ticks accepted as in-lock.
- MISS_FRAMES, 3: frame wraps with no sync edge before LOCKED goes to HOLDOVER.
- RD_SLOT, 974: slot in which the RAM0 read window opens.
- RD_LEN, 16: width of the read window in clocks.

Ports:
- clk  in  1  80 MHz system clock
- rst  in  1  reset, asynchronous, active-high
- sync_in  in  1  asynchronous frame sync pulse, at least 2 clk wide
- tod_h  out  21  slot index, 0..SLOT_MAX
- tod_l  out  11  tick within slot, 0..TICKS_PER_SLOT-1
- slot_start  out  1  high for the one clock where tod_l==0
- frame_start  out  1  high for the one clock where tod_h==0 && tod_l==0
- ram0_rd_en  out  1  RAM0 read window
- lock_state  out  2  00 UNLOCKED, 01 ACQUIRE, 10 LOCKED, 11 HOLDOVER
- slip_cnt  out  16  count of in-tolerance non-zero corrections, saturating

Behaviour:
- **Reset values:** all outputs 0, state UNLOCKED, miss counter 0.
- **Counting:**
  - tod_l increments every clk.
  - At TICKS_PER_SLOT-1, tod_l goes to 0 and tod_h increments.
  - tod_h wraps from SLOT_MAX to 0.
- **Registered strobes:** slot_start, frame_start and ram0_rd_en are registered and decoded from the next-count value, so they align with the tod values they describe.
- **Read window:** ram0_rd_en=1 iff tod_h==RD_SLOT && tod_l<RD_LEN. It is contiguous and opens once per frame.
- **Sync path:** sync_in passes through a 2-FF synchroniser and a rising-edge detector, giving a 1-clk pulse sync_rise.
- **Target:** the clock after sync_rise must show tod_h=0, tod_l=SYNC_LAT.
- **Phase error:**
  - e = (natural next position) − (target), signed, in ticks, wrap-aware across the frame boundary.
  - Only slot SLOT_MAX and slot 0 need evaluation.
  - Any other position counts as |e|>TOL.
- **Load:** forces the next count to the target.
- **State machine (evaluated on sync_rise and on frame wrap):**
  - UNLOCKED: free-runs. On sync_rise, load and go to ACQUIRE.
  - ACQUIRE:
    - sync_rise with |e|<=TOL: go to LOCKED, correct if e!=0.
    - sync_rise with |e|>TOL: load, stay in ACQUIRE.
    - MISS_FRAMES wraps with no edge: go to UNLOCKED.
  - LOCKED:
    - sync_rise with e==0: no change.
    - sync_rise with 0<|e|<=TOL: load, increment slip_cnt.
    - sync_rise with |e|>TOL: load, go to ACQUIRE.
    - MISS_FRAMES consecutive frame wraps with no sync_rise: go to HOLDOVER, keep free-running.
  - HOLDOVER:
    - sync_rise with |e|<=TOL: go to LOCKED, correct.
    - sync_rise with |e|>TOL: load, go to ACQUIRE.
- **Miss counter:** cleared by every sync_rise, incremented on every frame wrap, saturates at MISS_FRAMES.
- **Edge on the wrap clock:** a sync_rise on the same clock as a natural frame wrap is evaluated against the wrapped value. Load has priority over wrap and the miss counter is cleared.
- **Load side effects:**
  - A load never produces a spurious frame_start or slot_start.
  - A load that skips or repeats part of slot RD_SLOT may truncate or repeat the window; the downstream controller tolerates this because its address saturates.
- **slip_cnt** saturates at 16'hFFFF and is cleared only by rst.
- **rst mid-operation:** immediate return to the reset values; no strobes are emitted.

Optional Feature:
- Macro: TOD_INTERNAL_SYNC_EN.
- When defined:
  - sync_in is ignored.
  - An internal generator produces a 1-clk pulse every (SLOT_MAX+1)*TICKS_PER_SLOT clocks, first pulse 100 clocks after reset release.
  - The pulse feeds the same detector path after the synchroniser, with the same latency compensation.
  - Used for DSP-less bring-up together with the controller's test mode.
- When undefined: external sync only; no generator logic is present.

Test Plan:
1. Release rst, no sync for 2 frames → lock_state=00; tod_h sequence 0..976 wraps; tod_l 0..1999; exactly one frame_start per 1,954,000 clk.
2. Sync pulse at arbitrary time (tod_h=300) → lock_state=01; the clock after sync_rise shows tod_h=0, tod_l=3. A second pulse exactly one frame later → lock_state=10, slip_cnt=0.
3. In LOCKED, next pulse 5 clocks early → counter reloaded, slip_cnt=1, still 10. Next pulse 20 clocks late → lock_state=01.
4. In LOCKED, remove sync for 3 frames → lock_state=11 at the third wrap; an in-tolerance pulse afterwards → 10.
5. Window check → ram0_rd_en high for exactly 16 clocks at tod_h=974, tod_l=0..15 each frame. Assert rst at tod_h=974, tod_l=8 → ram0_rd_en drops to 0 immediately and all outputs return to 0.
6. With TOD_INTERNAL_SYNC_EN defined → reaches LOCKED after the second internal pulse with slip_cnt stable at 0 over 5 frames.
